nway_q31_arbmux: RTL and testbench
==================================

# nway_q31_arbmux

Registered N-way Q31 multiplexer with request/grant arbitration for the G.729 datapath. Several pre-processing and LPC sub-blocks take turns driving one shared Q31 operand bus, such as the shared L_add/L_mult input or a scratch-memory write port. The block arbitrates between them with round-robin or fixed priority and holds the grant until the owner releases. It registers the selected word and bounds ownership with a watchdog, so a stuck requester cannot starve the others.

## Interface
- N, 4, number of requesting channels (2..8)
- W, 32, data width in bits (Q31 = 32)
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- HOLD_MAX, 64, maximum ownership length in cycles before forced release (0 = watchdog disabled)

- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low reset
- req  input  N  per-channel request, level-sensitive
- done  input  N  per-channel release strobe; only the owner's bit is honoured
- data_in  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W]
- out  output  W  registered selected Q31 word
- valid  output  1  high while out carries the owner's data
- grant  output  N  one-hot owner indication, all-zero when idle
- busy  output  1  high in state OWN
- timeout  output  1  one-cycle pulse on a watchdog-forced release

## Operation
- The FSM has two states, IDLE and OWN.
- IDLE:
  - If req is nonzero, choose the winner and move to OWN.
  - grant becomes one-hot for the winner, out takes data_in[winner], valid and busy go to 1, and the hold counter loads 1.
- Winner selection:
  - RR=1: search upward from pointer ptr, wrapping at N-1 to 0; the first set req bit wins.
  - RR=0: the lowest set index wins and ptr is unused.
- OWN:
  - out reloads data_in[owner] on every cycle. This is a live pass-through with one register stage, not a latched value.
  - The hold counter increments, saturating at HOLD_MAX.
- Release happens on the first of these three events sampled in OWN:
  - done[owner]=1
  - req[owner]=0
  - HOLD_MAX != 0 and the counter equals HOLD_MAX
- On release, at that edge:
  - state returns to IDLE; grant, valid and busy clear; out holds its last value.
  - If RR=1, ptr becomes (owner+1) mod N.
  - timeout pulses for one cycle only if the watchdog caused the release, and never when done or a dropped req is sampled in the same cycle.
- done or req changes on channels other than the owner are ignored during OWN.
- Simultaneous requests are resolved in a single cycle by the selection rule; the losers stay pending and are not queued.
- IDLE always lasts at least one cycle between owners. A re-request by the previous owner competes normally, and in RR mode it is lowest priority.
- Hold counter width is clog2(HOLD_MAX+1), or 1 bit when HOLD_MAX is 0.
- Data is not modified: no saturation or rounding, W bits pass through unchanged.
- Reset (asynchronous, active-low):
  - state goes to IDLE; out = 0, valid = 0, grant = 0, busy = 0, timeout = 0, ptr = 0, counter = 0.
  - Reset asserted mid-ownership clears everything immediately, with no release pulse.
  - The first arbitration happens at the first rising edge after reset deasserts.

## Timing
- Grant latency: req sampled high in IDLE at edge t gives grant, valid and out at edge t; these are visible in the cycle after t.
- Data latency: data_in[owner] present before edge t appears on out after edge t, a one-cycle register delay.
- Release latency: done sampled at edge t clears grant and valid after edge t. The earliest next grant is at edge t+1.
- Maximum ownership is HOLD_MAX cycles of valid=1.
- RR fairness: with all N channels continuously requesting and never releasing, each channel is granted once every N×(HOLD_MAX+1) cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-OWN:
  - Stimulus: N=4, RR=1. Grant channel 2 with data_in[2]=0x7FFFFFFF, then pull reset low.
  - Required: out=0, grant=0, valid=0 immediately. After release, req=0b1111 grants channel 0.
- Round-robin rotation:
  - Stimulus: req=0b1111 held high; each owner asserts done on its 3rd cycle.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one IDLE cycle between owners.
- Fixed priority:
  - Stimulus: RR=0, req=0b1010.
  - Required: channel 1 granted. After release with req still 0b1010, channel 1 is granted again; channel 3 never is.
- Pass-through:
  - Stimulus: owner channel 3, data_in[3] stepping 0x80000000, 0x00000001, 0xFFFFFFFF on consecutive cycles.
  - Required: out shows the same sequence one cycle later, valid=1 throughout.
- Watchdog:
  - Stimulus: HOLD_MAX=4; channel 0 holds req with no done.
  - Required: valid=1 for exactly 4 cycles, timeout pulses once, then channel 1 (also requesting) is granted.
- Ignored strobes:
  - Stimulus: channel 2 owns the bus; done[1] and done[3] pulse, req[0] toggles.
  - Required: grant stays 0100 until done[2]; timeout stays 0.

Source files
------------

// File: rtl/nway_q31_arbmux.sv
// Registered N-way Q31 bus multiplexer with request/grant arbitration
// and an ownership watchdog.
module nway_q31_arbmux #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int RR       = 1,
    parameter int HOLD_MAX = 64
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_i,
    input  logic [N-1:0]   done_i,
    input  logic [N*W-1:0] data_in_i,
    output logic [W-1:0]   out_o,
    output logic           valid_o,
    output logic [N-1:0]   grant_o,
    output logic           busy_o,
    output logic           timeout_o
);

    localparam int PW = $clog2(N);
    localparam int CW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   out_q, out_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           timeout_q, timeout_d;

    logic [PW-1:0]  win;
    logic [PW-1:0]  cand;
    logic           found;
    logic [W-1:0]   win_data;
    logic [W-1:0]   own_data;
    logic           rel_done;
    logic           rel_drop;
    logic           hold_hit;
    logic [PW-1:0]  ptr_next;

    function automatic logic [PW-1:0] rr_idx(
        input logic [PW-1:0] base,
        input int            off
    );
        int j;
        j = int'(base) + off;
        if (j >= N) j = j - N;
        return PW'(j);
    endfunction

    // Search order starts at ptr in round-robin mode, at 0 otherwise.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = (RR != 0) ? rr_idx(ptr_q, i) : PW'(i);
            if (!found && req_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign win_data = data_in_i[int'(win)*W +: W];
    assign own_data = data_in_i[int'(owner_q)*W +: W];

    assign rel_done = done_i[owner_q];
    assign rel_drop = !req_i[owner_q];
    assign hold_hit = (HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX));
    assign ptr_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = OWN;
                    owner_d      = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    out_d        = win_data;
                    cnt_d        = CW'(1);
                end
            end
            OWN: begin
                if (rel_done || rel_drop || hold_hit) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    cnt_d     = '0;
                    timeout_d = hold_hit && !rel_done && !rel_drop;
                    if (RR != 0) ptr_d = ptr_next;
                end else begin
                    out_d = own_data;
                    if (HOLD_MAX != 0 && cnt_q != CW'(HOLD_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign out_o     = out_q;
    assign valid_o   = (state_q == OWN);
    assign busy_o    = (state_q == OWN);
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_nway_q31_arbmux.sv
// Bench for nway_q31_arbmux: directed scenarios plus random traffic,
// two instances (round-robin with watchdog, fixed priority without).
module tb_nway_q31_arbmux;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   done  = '0;
    logic [N*W-1:0] data  = '0;

    logic [W-1:0] a_out, b_out;
    logic         a_valid, b_valid;
    logic [N-1:0] a_grant, b_grant;
    logic         a_busy, b_busy;
    logic         a_timeout, b_timeout;

    always #5 clk = ~clk;

    nway_q31_arbmux #(.N(N), .W(W), .RR(1), .HOLD_MAX(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
        .data_in_i(data), .out_o(a_out), .valid_o(a_valid),
        .grant_o(a_grant), .busy_o(a_busy), .timeout_o(a_timeout)
    );

    nway_q31_arbmux #(.N(N), .W(W), .RR(0), .HOLD_MAX(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
        .data_in_i(data), .out_o(b_out), .valid_o(b_valid),
        .grant_o(b_grant), .busy_o(b_busy), .timeout_o(b_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference: owner index (-1 = idle), hold length, rr pointer
    int           m_own[2];
    int           m_cnt[2];
    int           m_ptr[2];
    logic [W-1:0] m_out[2];
    logic         m_to[2];
    int           m_rr[2] = '{1, 0};
    int           m_hm[2] = '{4, 0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1;
            m_cnt[d] = 0;
            m_ptr[d] = 0;
            m_out[d] = '0;
            m_to[d]  = 1'b0;
        end
    endtask

    task automatic model_step();
        int  w;
        int  c;
        int  o;
        bit  dn, dr, wd;
        for (int d = 0; d < 2; d++) begin
            if (m_own[d] < 0) begin
                m_to[d] = 1'b0;
                if (req != 0) begin
                    w = -1;
                    for (int i = 0; i < N; i++) begin
                        c = (m_rr[d] != 0) ? (m_ptr[d] + i) % N : i;
                        if (w < 0 && req[c]) w = c;
                    end
                    m_own[d] = w;
                    m_cnt[d] = 1;
                    m_out[d] = data[w*W +: W];
                end
            end else begin
                o  = m_own[d];
                dn = done[o];
                dr = !req[o];
                wd = (m_hm[d] != 0) && (m_cnt[d] == m_hm[d]);
                if (dn || dr || wd) begin
                    m_to[d] = wd && !dn && !dr;
                    if (m_rr[d] != 0) m_ptr[d] = (o + 1) % N;
                    m_own[d] = -1;
                end else begin
                    m_to[d]  = 1'b0;
                    m_out[d] = data[o*W +: W];
                    if (m_cnt[d] < m_hm[d]) m_cnt[d]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] o, g;
        logic        v, b, t;
        logic [31:0] eg;
        string       p;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                p = "a"; o = a_out; g = 32'(a_grant);
                v = a_valid; b = a_busy; t = a_timeout;
            end else begin
                p = "b"; o = b_out; g = 32'(b_grant);
                v = b_valid; b = b_busy; t = b_timeout;
            end
            eg = (m_own[d] >= 0) ? (32'd1 << m_own[d]) : 32'd0;
            chk({p, ".out"}, o, m_out[d]);
            chk({p, ".grant"}, g, eg);
            chk({p, ".valid"}, 32'(v), 32'(m_own[d] >= 0));
            chk({p, ".busy"}, 32'(b), 32'(m_own[d] >= 0));
            chk({p, ".timeout"}, 32'(t), 32'(m_to[d]));
        end
    endtask

    task automatic cycle();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] pv[3];
        int vcnt;
        int tcnt;
        pv[0] = 32'h8000_0000;
        pv[1] = 32'h0000_0001;
        pv[2] = 32'hFFFF_FFFF;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during ownership of channel 2
        req = 4'b0100;
        data[2*W +: W] = 32'h7FFF_FFFF;
        cycle();
        chk("rst.pre_grant", 32'(a_grant), 32'h4);
        chk("rst.pre_out", a_out, 32'h7FFF_FFFF);
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst.out", a_out, 32'h0);
        chk("rst.grant", 32'(a_grant), 32'h0);
        chk("rst.valid", 32'(a_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;

        // Round-robin rotation, owner releases on its third cycle
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rot.grant", 32'(a_grant), 32'd1 << (k % 4));
            cycle();
            cycle();
            done = 4'(1 << (k % 4));
            cycle();
            done = '0;
            chk("rot.idle", 32'(a_grant), 32'h0);
        end
        req = '0;
        cycle();

        // Pass-through on channel 3
        req = 4'b1000;
        data[3*W +: W] = 32'h1234_5678;
        cycle();
        chk("pt.grant", 32'(a_grant), 32'h8);
        chk("pt.first", a_out, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            data[3*W +: W] = pv[i];
            cycle();
            chk("pt.out", a_out, pv[i]);
            chk("pt.valid", 32'(a_valid), 32'h1);
        end
        req = '0;
        cycle();

        // Watchdog: channel 0 never releases, channel 1 waits
        req = 4'b0011;
        cycle();
        chk("wd.grant", 32'(a_grant), 32'h1);
        vcnt = 0;
        tcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_valid && a_grant == 4'b0001) vcnt++;
            cycle();
            if (a_timeout) tcnt++;
        end
        chk("wd.valid_cycles", 32'(vcnt), 32'd4);
        chk("wd.timeouts", 32'(tcnt), 32'd1);
        chk("wd.next", 32'(a_grant), 32'h2);
        req = '0;
        cycle();
        cycle();

        // Strobes from non-owners are ignored
        req = 4'b0100;
        cycle();
        chk("ign.grant0", 32'(a_grant), 32'h4);
        done = 4'b1010;
        cycle();
        chk("ign.grant1", 32'(a_grant), 32'h4);
        chk("ign.to1", 32'(a_timeout), 32'h0);
        done = '0;
        req = 4'b0101;
        cycle();
        chk("ign.grant2", 32'(a_grant), 32'h4);
        done = 4'b0100;
        req = 4'b0100;
        cycle();
        chk("ign.release", 32'(a_grant), 32'h0);
        chk("ign.to", 32'(a_timeout), 32'h0);
        done = '0;
        req = '0;
        cycle();

        // Fixed priority on instance b
        req = 4'b1010;
        cycle();
        chk("fp.grant", 32'(b_grant), 32'h2);
        cycle();
        done = 4'b0010;
        cycle();
        chk("fp.release", 32'(b_grant), 32'h0);
        done = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fp.regrant", 32'(b_grant), 32'h2);
        end
        req = '0;
        cycle();

        // Random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                req  = 4'($urandom);
                done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                data = {$urandom, $urandom, $urandom, $urandom};
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
